// File: rtl/psum_accum_writer.sv
// psum_accum_writer
//
// Accumulates signed partial sums from the kernel-channel PE array into a
// psum BRAM over P passes of N outputs each. Pass 0 overwrites each word with
// the sign-extended psum. Later passes read the old word and write back the
// signed saturating sum.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-low reset
//   i_conf_ctrl         bit0 start (0->1 edge), bit1 soft clear
//   i_conf_outputsize   last output index per pass (N-1)
//   i_conf_numpass      number of passes minus one (P-1)
//   o_conf_status       bit0 busy, bit1 done, bit2 sticky saturation
//   i_psum_valid/_data  upstream psum stream
//   o_psum_ready        high only in RUN
//   mem_raddr/mem_odat  BRAM read port (1-cycle latency, read-first)
//   mem_waddr/mem_idat  BRAM write port
//   mem_wren, mem_enb   byte write enables (all or none), BRAM enable
//   dbg_state           current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: a beat transfers in any cycle where i_psum_valid and
// o_psum_ready are both high. The producer may hold valid high at any time;
// a beat offered while ready is low is neither consumed nor remembered.
//
// Pipeline for a beat accepted in cycle t:
//   t+1  stage 1: read address on mem_raddr
//   t+2  stage 2: mem_odat (or forwarded write data) added to the psum
//   t+3  stage 3: write driven on mem_waddr/mem_idat/mem_wren
module psum_accum_writer #(
  parameter int PSUM_WIDTH = 20,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_WIDTH-1:0]  i_conf_ctrl,
  input  logic [REG_WIDTH-1:0]  i_conf_outputsize,
  input  logic [REG_WIDTH-1:0]  i_conf_numpass,
  output logic [REG_WIDTH-1:0]  o_conf_status,
  input  logic                  i_psum_valid,
  input  logic [PSUM_WIDTH-1:0] i_psum_data,
  output logic                  o_psum_ready,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_odat,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_idat,
  output logic [3:0]            mem_wren,
  output logic                  mem_enb,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  // Control
  logic                  start_q;
  logic                  start_edge;
  logic                  soft_clr;
  logic                  launch;
  logic                  accept;
  logic                  last_beat;
  logic [REG_WIDTH-1:0]  cfg_last_idx;
  logic [REG_WIDTH-1:0]  cfg_last_pass;
  logic [REG_WIDTH-1:0]  idx;
  logic [REG_WIDTH-1:0]  pass_cnt;
  logic                  sat_flag;

  // Datapath
  logic [ADDR_WIDTH-1:0] idx_addr;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [DATA_WIDTH-1:0] psum_ext;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_psum;
  logic                  s1_first;
  logic                  s2_valid;
  logic [ADDR_WIDTH-1:0] s2_addr;
  logic [DATA_WIDTH-1:0] s2_psum;
  logic                  s2_first;
  logic                  w4_valid;
  logic [ADDR_WIDTH-1:0] w4_addr;
  logic [DATA_WIDTH-1:0] w4_data;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH:0]   sum_wide;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  sat_hit;

  // Upper control bits are reserved.
  logic unused_ctrl;
  assign unused_ctrl = &{1'b0, i_conf_ctrl[REG_WIDTH-1:2]};

  assign start_edge = i_conf_ctrl[0] & ~start_q;
  assign soft_clr   = i_conf_ctrl[1];
  assign accept     = (state == S_RUN) && i_psum_valid;
  assign last_beat  = accept && (idx == cfg_last_idx) && (pass_cnt == cfg_last_pass);
  // A start edge only launches from IDLE/DONE; while busy it is ignored.
  assign launch     = start_edge && !soft_clr && ((state == S_IDLE) || (state == S_DONE));

  assign idx_addr  = ADDR_WIDTH'(idx);
  assign beat_addr = {idx_addr[ADDR_WIDTH-3:0], 2'b00};
  assign psum_ext  = DATA_WIDTH'($signed(i_psum_data));

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_edge) state_nxt = S_RUN;
      S_RUN:   if (last_beat) state_nxt = S_DRAIN;
      // Once stage 1 is empty the last beat is in stage 2 and its write is
      // driven in the first DONE cycle, which is the third after acceptance.
      S_DRAIN: if (!s1_valid) state_nxt = S_DONE;
      S_DONE:  if (start_edge) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
    if (soft_clr) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      start_q       <= 1'b0;
      cfg_last_idx  <= '0;
      cfg_last_pass <= '0;
      idx           <= '0;
      pass_cnt      <= '0;
      sat_flag      <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_q <= i_conf_ctrl[0];
      if (soft_clr) begin
        idx      <= '0;
        pass_cnt <= '0;
        sat_flag <= 1'b0;
      end else if (launch) begin
        idx           <= '0;
        pass_cnt      <= '0;
        sat_flag      <= 1'b0;
        cfg_last_idx  <= i_conf_outputsize;
        cfg_last_pass <= i_conf_numpass;
      end else begin
        if (accept) begin
          if (idx == cfg_last_idx) begin
            idx      <= '0;
            pass_cnt <= pass_cnt + REG_WIDTH'(1);
          end else begin
            idx <= idx + REG_WIDTH'(1);
          end
        end
        if (sat_hit) sat_flag <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage-2 read-modify. The BRAM read for this beat was sampled on the edge
  // that also committed the write from the previous cycle (read-first, so the
  // old value), and the write in the current cycle has not committed yet.
  // Both are forwarded, the current-cycle write being the newer.
  // ---------------------------------------------------------------------------
  always_comb begin
    old_word = mem_odat;
    if (w4_valid && (w4_addr == s2_addr)) old_word = w4_data;
    if ((mem_wren == 4'hF) && (mem_waddr == s2_addr)) old_word = mem_idat;

    sum_wide = {old_word[DATA_WIDTH-1], old_word} + {s2_psum[DATA_WIDTH-1], s2_psum};
    wr_data  = sum_wide[DATA_WIDTH-1:0];
    sat_hit  = 1'b0;
    if (s2_first) begin
      wr_data = s2_psum;
    end else if (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1]) begin
      sat_hit = s2_valid;
      wr_data = sum_wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      mem_raddr <= '0;
      s1_psum   <= '0;
      s1_first  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_addr   <= '0;
      s2_psum   <= '0;
      s2_first  <= 1'b0;
      mem_wren  <= 4'h0;
      mem_waddr <= '0;
      mem_idat  <= '0;
      w4_valid  <= 1'b0;
      w4_addr   <= '0;
      w4_data   <= '0;
    end else if (soft_clr) begin
      // Everything in flight is dropped; no write may follow a clear.
      s1_valid  <= 1'b0;
      mem_raddr <= '0;
      s1_psum   <= '0;
      s1_first  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_addr   <= '0;
      s2_psum   <= '0;
      s2_first  <= 1'b0;
      mem_wren  <= 4'h0;
      mem_waddr <= '0;
      mem_idat  <= '0;
      w4_valid  <= 1'b0;
      w4_addr   <= '0;
      w4_data   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        mem_raddr <= beat_addr;
        s1_psum   <= psum_ext;
        s1_first  <= (pass_cnt == '0);
      end
      s2_valid <= s1_valid;
      s2_addr  <= mem_raddr;
      s2_psum  <= s1_psum;
      s2_first <= s1_first;
      mem_wren <= s2_valid ? 4'hF : 4'h0;
      if (s2_valid) begin
        mem_waddr <= s2_addr;
        mem_idat  <= wr_data;
      end
      w4_valid <= (mem_wren == 4'hF);
      w4_addr  <= mem_waddr;
      w4_data  <= mem_idat;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_psum_ready  = (state == S_RUN);
  // The final write lands in the first DONE cycle, so the enable also
  // follows the write strobe.
  assign mem_enb       = (state == S_RUN) || (state == S_DRAIN) || (mem_wren != 4'h0);
  assign o_conf_status = REG_WIDTH'({sat_flag, (state == S_DONE),
                                     ((state == S_RUN) || (state == S_DRAIN))});
  assign dbg_state     = state;

endmodule

// File: tb/tb_psum_accum_writer.sv
module tb_psum_accum_writer;
  localparam int PW = 20;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [RW-1:0] i_conf_ctrl, i_conf_outputsize, i_conf_numpass, o_conf_status;
  logic          i_psum_valid;
  logic [PW-1:0] i_psum_data;
  logic          o_psum_ready;
  logic [AW-1:0] mem_raddr, mem_waddr;
  logic [DW-1:0] mem_odat = '0;
  logic [DW-1:0] mem_idat;
  logic [3:0]    mem_wren;
  logic          mem_enb;
  logic [1:0]    dbg_state;

  psum_accum_writer #(
    .PSUM_WIDTH(PW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_WIDTH(RW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .i_conf_ctrl       (i_conf_ctrl),
    .i_conf_outputsize (i_conf_outputsize),
    .i_conf_numpass    (i_conf_numpass),
    .o_conf_status     (o_conf_status),
    .i_psum_valid      (i_psum_valid),
    .i_psum_data       (i_psum_data),
    .o_psum_ready      (o_psum_ready),
    .mem_raddr         (mem_raddr),
    .mem_odat          (mem_odat),
    .mem_waddr         (mem_waddr),
    .mem_idat          (mem_idat),
    .mem_wren          (mem_wren),
    .mem_enb           (mem_enb),
    .dbg_state         (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // BRAM model: 16 words, one-cycle read latency, read-first; poke port lets
  // the stimulus preload words.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem [0:15];
  logic          poke_en;
  logic [3:0]    poke_a;
  logic [DW-1:0] poke_d;

  always @(posedge clk) begin
    if (mem_enb) mem_odat <= mem[mem_raddr[5:2]];
    if (mem_wren == 4'hF) mem[mem_waddr[5:2]] <= mem_idat;
    if (poke_en) mem[poke_a] <= poke_d;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] w;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Every accepted beat must produce exactly one write 3 cycles later.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (i_psum_valid && o_psum_ready) exp_q.push_back(cyc + 32'd3);
      if (mem_wren !== 4'h0) begin
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL spurious_write observed wren=0x%0h at cycle %0d expected no write", mem_wren, cyc);
        end
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          chk("write_latency_cycle", 64'(cyc), 64'(w));
        end
        chk("wren_all_bytes", 64'(mem_wren), 64'h F);
      end else if (exp_q.size() != 0 && exp_q[0] < cyc) begin
        chk("missed_write_cycle", 64'(cyc), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int a, input logic [DW-1:0] d);
    poke_en = 1'b1;
    poke_a  = 4'(a);
    poke_d  = d;
    tick();
    poke_en = 1'b0;
  endtask

  task automatic start(input logic [RW-1:0] osz, input logic [RW-1:0] np);
    i_conf_ctrl = '0;
    tick();
    i_conf_outputsize = osz;
    i_conf_numpass    = np;
    i_conf_ctrl       = 32'h1;
    tick();
  endtask

  task automatic beat(input logic [PW-1:0] d);
    i_psum_valid = 1'b1;
    i_psum_data  = d;
    tick();
    i_psum_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=time-limit expected=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int e [4];
  int v;
  logic [31:0] ev;

  initial begin
    rst = 1'b0;
    i_conf_ctrl = '0; i_conf_outputsize = '0; i_conf_numpass = '0;
    i_psum_valid = 1'b0; i_psum_data = '0;
    poke_en = 1'b0; poke_a = '0; poke_d = '0;
    #12;
    chk("rst_ready",  64'(o_psum_ready), 64'h0);
    chk("rst_wren",   64'(mem_wren), 64'h0);
    chk("rst_enb",    64'(mem_enb), 64'h0);
    chk("rst_raddr",  64'(mem_raddr), 64'h0);
    chk("rst_waddr",  64'(mem_waddr), 64'h0);
    chk("rst_idat",   64'(mem_idat), 64'h0);
    chk("rst_status", 64'(o_conf_status), 64'h0);
    chk("rst_state",  64'(dbg_state), 64'h0);
    tick();
    rst = 1'b1;
    tick();

    // Valid in IDLE is not consumed.
    i_psum_valid = 1'b1; i_psum_data = 20'h5;
    tick(); tick();
    chk("idle_ready", 64'(o_psum_ready), 64'h0);
    chk("idle_status", 64'(o_conf_status), 64'h0);
    i_psum_valid = 1'b0;

    // N=4, P=1, psums 1..4 back-to-back; garbage in word 0 is ignored.
    poke(0, 32'hAAAA_AAAA);
    start(32'd3, 32'd0);
    chk("run_ready", 64'(o_psum_ready), 64'h1);
    chk("run_status", 64'(o_conf_status), 64'h1);
    chk("run_state", 64'(dbg_state), 64'h1);
    for (int k = 0; k < 4; k++) begin
      beat(20'(k + 1));
      chk("p1_raddr", 64'(mem_raddr), 64'(k * 4));
    end
    chk("p1_drain_ready", 64'(o_psum_ready), 64'h0);
    chk("p1_drain_state", 64'(dbg_state), 64'h2);
    chk("p1_status_l1", 64'(o_conf_status), 64'h1);
    tick();
    chk("p1_status_l2", 64'(o_conf_status), 64'h1);
    tick();
    chk("p1_status_done", 64'(o_conf_status), 64'h2);
    chk("p1_last_idat", 64'(mem_idat), 64'h4);
    chk("p1_last_waddr", 64'(mem_waddr), 64'hC);
    chk("p1_done_state", 64'(dbg_state), 64'h3);
    tick();
    for (int i = 0; i < 4; i++) chk("p1_word", 64'(mem[i]), 64'(i + 1));

    // N=4, P=3, constant 5; config changed mid-run must not matter.
    start(32'd3, 32'd2);
    i_conf_outputsize = '0;
    i_conf_numpass    = '0;
    repeat (12) beat(20'd5);
    tick(); tick();
    chk("p3_status", 64'(o_conf_status), 64'h2);
    tick();
    for (int i = 0; i < 4; i++) chk("p3_word", 64'(mem[i]), 64'd15);

    // N=1, P=4, psums 7,-2,3,1 -> 9 through forwarding.
    poke(0, 32'h100);
    start(32'd0, 32'd3);
    beat(20'd7); beat(20'hFFFFE); beat(20'd3); beat(20'd1);
    chk("fwd_idat_b1", 64'(mem_idat), 64'd5);
    chk("fwd_status_drain", 64'(o_conf_status), 64'h1);
    tick();
    chk("fwd_idat_b2", 64'(mem_idat), 64'd8);
    tick();
    chk("fwd_idat_b3", 64'(mem_idat), 64'd9);
    chk("fwd_status_done", 64'(o_conf_status), 64'h2);
    tick();
    chk("fwd_word", 64'(mem[0]), 64'd9);

    // Saturation: pass 1 adds 0x7FFF0 onto a preloaded 0x7FFFFFFF.
    start(32'd1, 32'd1);
    beat(20'd1); beat(20'd2);
    repeat (4) tick();
    poke(0, 32'h7FFF_FFFF);
    beat(20'h7FFF0); beat(20'd3);
    chk("sat_status_l1", 64'(o_conf_status), 64'h1);
    tick();
    chk("sat_idat", 64'(mem_idat), 64'h7FFF_FFFF);
    chk("sat_status_l2", 64'(o_conf_status), 64'h5);
    tick();
    chk("sat_idat_w1", 64'(mem_idat), 64'd5);
    chk("sat_status_done", 64'(o_conf_status), 64'h6);
    tick();
    chk("sat_word0", 64'(mem[0]), 64'h7FFF_FFFF);
    chk("sat_word1", 64'(mem[1]), 64'd5);

    // Soft clear with two beats in flight.
    poke(0, 32'h55); poke(1, 32'h55);
    start(32'd3, 32'd0);
    beat(20'd9); beat(20'd9);
    i_conf_ctrl = 32'h3;
    exp_q.delete();
    tick();
    chk("clr_wren", 64'(mem_wren), 64'h0);
    chk("clr_status", 64'(o_conf_status), 64'h0);
    chk("clr_ready", 64'(o_psum_ready), 64'h0);
    chk("clr_state", 64'(dbg_state), 64'h0);
    i_conf_ctrl = '0;
    repeat (4) tick();
    chk("clr_word0", 64'(mem[0]), 64'h55);
    chk("clr_word1", 64'(mem[1]), 64'h55);
    start(32'd0, 32'd0);
    beat(20'd6);
    tick(); tick();
    chk("clr_rerun_status", 64'(o_conf_status), 64'h2);
    tick();
    chk("clr_rerun_word0", 64'(mem[0]), 64'd6);
    chk("clr_rerun_word1", 64'(mem[1]), 64'h55);

    // Asynchronous reset with two beats in flight.
    start(32'd3, 32'd0);
    beat(20'd9); beat(20'd9);
    i_conf_ctrl = '0;
    rst = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_wren", 64'(mem_wren), 64'h0);
    chk("arst_status", 64'(o_conf_status), 64'h0);
    chk("arst_raddr", 64'(mem_raddr), 64'h0);
    chk("arst_enb", 64'(mem_enb), 64'h0);
    tick(); tick();
    rst = 1'b1;
    i_psum_valid = 1'b1;
    tick(); tick();
    chk("arst_idle_ready", 64'(o_psum_ready), 64'h0);
    chk("arst_idle_state", 64'(dbg_state), 64'h0);
    i_psum_valid = 1'b0;
    repeat (3) tick();
    chk("arst_word0", 64'(mem[0]), 64'd6);
    start(32'd0, 32'd0);
    beat(20'd11);
    tick(); tick(); tick();
    chk("arst_rerun_word0", 64'(mem[0]), 64'd11);
    chk("arst_rerun_status", 64'(o_conf_status), 64'h2);

    // N=4, P=2 with random gaps; a start edge mid-run is ignored.
    for (int i = 0; i < 4; i++) e[i] = 0;
    start(32'd3, 32'd1);
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      if (k == 4) begin
        i_conf_ctrl = '0;
        tick();
        i_conf_ctrl = 32'h1;
        tick();
        chk("busy_start_ignored", 64'(o_conf_status), 64'h1);
      end
      v = int'($urandom_range(0, 2000)) - 1000;
      e[k % 4] += v;
      beat(v[19:0]);
    end
    tick(); tick();
    chk("gap_status", 64'(o_conf_status), 64'h2);
    tick();
    for (int i = 0; i < 4; i++) begin
      ev = e[i];
      chk("gap_word", 64'(mem[i]), 64'(ev));
    end

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
